// File: rtl/lfsr_pkg.sv
// Shared types and feedback helper for the LFSR generator/checker pair.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_t;

  // Widest register the feedback helper accepts; callers zero-extend to this width.
  localparam int unsigned LFSR_MAX_N = 32;

  function automatic logic lfsr_feedback(input logic [LFSR_MAX_N-1:0] h,
                                         input logic [LFSR_MAX_N-1:0] taps);
    return ^(h & taps);
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Bit-stream, configuration and status bundle between a link and the PRBS checker.
interface lfsr_checker_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned ERR_W = 16
);
  logic             load_config_i;
  logic [N-1:0]     taps_i;
  logic             data_i;
  logic             valid_i;
  logic             clear_i;
  logic             locked_o;
  logic             check_o;
  logic             error_o;
  logic [ERR_W-1:0] err_count_o;

  modport master (
    output load_config_i, taps_i, data_i, valid_i, clear_i,
    input  locked_o, check_o, error_o, err_count_o
  );

  modport slave (
    input  load_config_i, taps_i, data_i, valid_i, clear_i,
    output locked_o, check_o, error_o, err_count_o
  );
endinterface

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module lfsr_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (clr_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising serial PRBS checker: SEARCH -> VERIFY -> LOCKED with windowed unlock.
// Build option: LFSR_CHECKER_FLYWHEEL_EN feeds predicted bits into the history while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned   N               = 8,
  parameter logic [N-1:0]  TAPS            = N'(8'b00000011),
  parameter bit            VARIABLE_CONFIG = 1'b0,
  parameter int unsigned   LOCK_COUNT      = 16,
  parameter int unsigned   UNLOCK_ERRORS   = 4,
  parameter int unsigned   UNLOCK_WINDOW   = 64,
  parameter int unsigned   ERR_W           = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  lfsr_checker_if.slave bus
);

  localparam int unsigned FILL_W = $clog2(N + 1);
  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WIN_W  = (UNLOCK_WINDOW > 1) ? $clog2(UNLOCK_WINDOW) : 1;
  localparam int unsigned WERR_W = $clog2(UNLOCK_ERRORS + 1);

  lfsr_state_t       state;
  logic [N-1:0]      hist;
  logic [N-1:0]      taps_q;
  logic [FILL_W-1:0] fill_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [WERR_W-1:0] win_err;
  logic              locked_q;
  logic              check_q;
  logic              error_q;

  logic              pred;
  logic              mismatch;
  logic              load_evt;
  logic              shift_bit;
  logic [N-1:0]      hist_next;
  logic              err_inc;
  logic              err_clr;

  assign pred     = lfsr_feedback(LFSR_MAX_N'(hist), LFSR_MAX_N'(taps_q));
  assign mismatch = bus.data_i ^ pred;
  assign load_evt = VARIABLE_CONFIG && bus.load_config_i;

  always_comb begin
    shift_bit = bus.data_i;
`ifdef LFSR_CHECKER_FLYWHEEL_EN
    if (state == LOCKED) begin
      shift_bit = pred;
    end
`endif
    hist_next = {shift_bit, hist[N-1:1]};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= SEARCH;
      hist     <= '0;
      taps_q   <= TAPS;
      fill_cnt <= '0;
      run_cnt  <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
      locked_q <= 1'b0;
      check_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      check_q <= 1'b0;
      error_q <= 1'b0;
      if (load_evt) begin
        // Reconfiguration restarts sync and drops the same-cycle bit.
        taps_q   <= bus.taps_i;
        state    <= SEARCH;
        hist     <= '0;
        fill_cnt <= '0;
        run_cnt  <= '0;
        win_cnt  <= '0;
        win_err  <= '0;
        locked_q <= 1'b0;
      end else if (bus.valid_i) begin
        hist <= hist_next;
        case (state)
          SEARCH: begin
            if (fill_cnt == FILL_W'(N - 1)) begin
              fill_cnt <= '0;
              run_cnt  <= '0;
              state    <= VERIFY;
            end else begin
              fill_cnt <= fill_cnt + FILL_W'(1);
            end
          end
          VERIFY: begin
            if (mismatch) begin
              run_cnt <= '0;
            end else if (run_cnt == RUN_W'(LOCK_COUNT - 1)) begin
              run_cnt <= '0;
              // An all-zero history satisfies any taps, so it must not lock.
              if (hist_next != '0) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                win_cnt  <= '0;
                win_err  <= '0;
              end else begin
                state    <= SEARCH;
                fill_cnt <= '0;
              end
            end else begin
              run_cnt <= run_cnt + RUN_W'(1);
            end
          end
          LOCKED: begin
            check_q <= 1'b1;
            error_q <= mismatch;
            if (mismatch && (win_err == WERR_W'(UNLOCK_ERRORS - 1))) begin
              state    <= SEARCH;
              locked_q <= 1'b0;
              fill_cnt <= '0;
              win_cnt  <= '0;
              win_err  <= '0;
            end else if (win_cnt == WIN_W'(UNLOCK_WINDOW - 1)) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + WIN_W'(1);
              if (mismatch) begin
                win_err <= win_err + WERR_W'(1);
              end
            end
          end
          default: begin
            state <= SEARCH;
          end
        endcase
      end
    end
  end

  // Count moves on the same edge that raises error_o.
  assign err_inc = !load_evt && bus.valid_i && (state == LOCKED) && mismatch;
  assign err_clr = bus.clear_i || load_evt;

  lfsr_sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (err_inc),
    .clr_i   (err_clr),
    .count_o (bus.err_count_o)
  );

  assign bus.locked_o = locked_q;
  assign bus.check_o  = check_q;
  assign bus.error_o  = error_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, error injection, stuck stream, unlock/relock, idle cycles, reconfig.
module tb_lfsr_checker;

`ifdef LFSR_CHECKER_FLYWHEEL_EN
  localparam bit FLY = 1'b1;
`else
  localparam bit FLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_config = 1'b0;
  logic [7:0] taps_in = 8'h00;
  logic       data = 1'b0;
  logic       valid = 1'b0;
  logic       clear = 1'b0;

  logic       sc_inc = 1'b0;
  logic       sc_clr = 1'b0;
  logic [1:0] sc_count;

  logic [7:0] gen;
  logic [7:0] gen_taps;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_checker_if #(.N(8), .ERR_W(16)) bus0 ();
  lfsr_checker_if #(.N(8), .ERR_W(16)) bus1 ();

  assign bus0.load_config_i = load_config;
  assign bus0.taps_i        = taps_in;
  assign bus0.data_i        = data;
  assign bus0.valid_i       = valid;
  assign bus0.clear_i       = clear;
  assign bus1.load_config_i = load_config;
  assign bus1.taps_i        = taps_in;
  assign bus1.data_i        = data;
  assign bus1.valid_i       = valid;
  assign bus1.clear_i       = clear;

  lfsr_checker #(
    .N(8), .TAPS(8'b00000011), .VARIABLE_CONFIG(1'b0), .LOCK_COUNT(16),
    .UNLOCK_ERRORS(4), .UNLOCK_WINDOW(64), .ERR_W(16)
  ) dut0 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus0.slave)
  );

  lfsr_checker #(
    .N(8), .TAPS(8'b00000011), .VARIABLE_CONFIG(1'b1), .LOCK_COUNT(16),
    .UNLOCK_ERRORS(4), .UNLOCK_WINDOW(64), .ERR_W(16)
  ) dut1 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus1.slave)
  );

  lfsr_sat_counter #(.WIDTH(2)) u_sat (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (sc_inc),
    .clr_i   (sc_clr),
    .count_o (sc_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic v);
    @(negedge clk);
    data  = b;
    valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_gen(input logic inv);
    logic b;
    b   = gen[0] ^ inv;
    gen = {^(gen & gen_taps), gen[7:1]};
    step(b, 1'b1);
  endtask

  task automatic restart(input logic [7:0] t);
    @(negedge clk);
    reset       = 1'b1;
    valid       = 1'b0;
    data        = 1'b0;
    load_config = 1'b0;
    clear       = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    gen      = 8'h01;
    gen_taps = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_locked", bus0.locked_o, 1'b0);
    chk("rst_check", bus0.check_o, 1'b0);
    chk("rst_error", bus0.error_o, 1'b0);
    chk("rst_count", bus0.err_count_o, 16'd0);

    // 1: clean stream locks after the 24th bit
    restart(8'b00000011);
    for (int unsigned i = 1; i <= 24; i++) begin
      send_gen(1'b0);
      chk("t1_locked", bus0.locked_o, (i == 24));
      chk("t1_check", bus0.check_o, 1'b0);
    end
    chk("t1_count", bus0.err_count_o, 16'd0);
    send_gen(1'b0);
    chk("t1_check_pulse", bus0.check_o, 1'b1);
    chk("t1_error", bus0.error_o, 1'b0);

    // 2: single inverted bit while locked; clear_i beats a same-cycle increment
    restart(8'b00000011);
    for (int unsigned i = 1; i <= 175; i++) begin
      clear = (i == 160);
      send_gen((i == 100) || (i == 160));
      clear = 1'b0;
      if (i > 24) begin
        chk("t2_locked", bus0.locked_o, 1'b1);
        chk("t2_error", bus0.error_o,
            (i == 100) || (i == 160) ||
            (!FLY && ((i == 107) || (i == 108) || (i == 167) || (i == 168))));
      end
      if (i == 150) chk("t2_count", bus0.err_count_o, FLY ? 16'd1 : 16'd3);
    end
    chk("t2_count_after_clear", bus0.err_count_o, FLY ? 16'd0 : 16'd2);

    // 3: all-zero stream never locks
    restart(8'b00000011);
    for (int unsigned i = 1; i <= 200; i++) begin
      step(1'b0, 1'b1);
      chk("t3_locked", bus0.locked_o, 1'b0);
      chk("t3_check", bus0.check_o, 1'b0);
    end

    // 4: four errors in one window drop lock, then relock after 24 clean bits
    restart(8'b00000011);
    for (int unsigned i = 1; i <= 63; i++) begin
      send_gen((i >= 35) && (i <= 38));
      chk("t4_locked", bus0.locked_o, ((i >= 24) && (i < 38)) || (i >= 62));
      chk("t4_error", bus0.error_o, (i >= 35) && (i <= 38));
    end
    chk("t4_count", bus0.err_count_o, 16'd4);

    // 5: idle cycles between valid bits do not move the lock point
    restart(8'b00000011);
    for (int unsigned i = 1; i <= 25; i++) begin
      send_gen(1'b0);
      chk("t5_locked", bus0.locked_o, (i >= 24));
      chk("t5_check", bus0.check_o, (i == 25));
      step(~gen[0], 1'b0);
      chk("t5_idle_locked", bus0.locked_o, (i >= 24));
      chk("t5_idle_check", bus0.check_o, 1'b0);
    end

    // 6: runtime taps reload, then asynchronous reset while locked
    restart(8'b00000011);
    for (int unsigned i = 1; i <= 29; i++) begin
      send_gen(i == 28);
    end
    chk("t6_pre_locked", bus1.locked_o, 1'b1);
    chk("t6_pre_count", bus1.err_count_o, 16'd1);
    taps_in     = 8'b00011101;
    load_config = 1'b1;
    send_gen(1'b0);
    load_config = 1'b0;
    chk("t6_load_locked", bus1.locked_o, 1'b0);
    chk("t6_load_count", bus1.err_count_o, 16'd0);
    chk("t6_load_check", bus1.check_o, 1'b0);
    chk("t6_fixed_locked", bus0.locked_o, 1'b1);
    chk("t6_fixed_count", bus0.err_count_o, 16'd1);
    chk("t6_fixed_check", bus0.check_o, 1'b1);
    gen      = 8'h01;
    gen_taps = 8'b00011101;
    for (int unsigned i = 1; i <= 24; i++) begin
      send_gen(1'b0);
      chk("t6_relock", bus1.locked_o, (i == 24));
    end
    reset = 1'b1;
    #1;
    chk("t6_async_locked", bus1.locked_o, 1'b0);
    chk("t6_async_count0", bus0.err_count_o, 16'd0);
    chk("t6_async_locked0", bus0.locked_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Saturating counter boundary at all-ones
    for (int unsigned k = 1; k <= 5; k++) begin
      @(negedge clk);
      sc_inc = 1'b1;
      @(posedge clk);
      #1;
      chk("sat_count", sc_count, (k > 3) ? 2'd3 : 2'(k));
    end
    @(negedge clk);
    sc_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("sat_clear_wins", sc_count, 2'd0);
    @(negedge clk);
    sc_inc = 1'b0;
    sc_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
